// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM states, oversampling constants
// and the three-sample majority vote.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling prescaler: one-cycle tick every DIV clocks; clear restarts the
// phase so the first tick lands DIV cycles after clear drops.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = !clear && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_16x.sv
// 16x oversampling UART receiver: start/data/parity/stop framing with a
// single-word holding register and valid/ready handoff.
module uart_rx_16x #(
  parameter int DATA_BITS  = 8,
  parameter int DIV        = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 locked,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  import uart_pkg::*;

  localparam logic [3:0] CNT_LO   = 4'(SAMPLE_LO);
  localparam logic [3:0] CNT_MID  = 4'(SAMPLE_MID);
  localparam logic [3:0] CNT_HI   = 4'(SAMPLE_HI);
  localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rxd_s;
  logic                 rxd_prev;
  uart_state_t          state;
  logic [3:0]           sample_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 s_lo;
  logic                 s_mid;
  logic                 perr_q;
  logic                 tick;
  logic                 bit_val;
  logic                 stop_decide;
  logic                 can_load;

  assign rxd_s       = sync_q[1];
  assign bit_val     = majority3(s_lo, s_mid, rxd_s);
  assign stop_decide = locked && tick && (state == ST_STOP) && (sample_cnt == CNT_HI);
  assign can_load    = !rx_valid || rx_ready;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk   (refclk),
    .rst   (rst),
    .clear ((state == ST_IDLE) || !locked),
    .tick  (tick)
  );

  // NOTE: synchronizer and edge-detect flops reset to 1 (idle line level) so
  // releasing reset can never look like a start-bit falling edge.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q   <= 2'b11;
      rxd_prev <= 1'b1;
    end else begin
      sync_q   <= {sync_q[0], rxd};
      rxd_prev <= sync_q[1];
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shift_q    <= '0;
      s_lo       <= 1'b1;
      s_mid      <= 1'b1;
      perr_q     <= 1'b0;
    end else if (!locked) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rxd_prev && !rxd_s) begin
            state      <= ST_START;
            sample_cnt <= '0;
            bit_idx    <= '0;
            perr_q     <= 1'b0;
          end
        end
        ST_WAIT_HIGH: begin
          if (rxd_s) state <= ST_IDLE;
        end
        default: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == CNT_LO)  s_lo  <= rxd_s;
            if (sample_cnt == CNT_MID) s_mid <= rxd_s;
            case (state)
              ST_START: begin
                if (sample_cnt == CNT_HI && bit_val) state <= ST_IDLE;
                else if (sample_cnt == CNT_LAST)     state <= ST_DATA;
              end
              ST_DATA: begin
                if (sample_cnt == CNT_HI) begin
                  shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                end else if (sample_cnt == CNT_LAST) begin
                  if (bit_idx == LAST_BIT) state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                  else                     bit_idx <= bit_idx + 3'd1;
                end
              end
              ST_PARITY: begin
                if (sample_cnt == CNT_HI)        perr_q <= bit_val != ((^shift_q) ^ (PARITY_ODD != 0));
                else if (sample_cnt == CNT_LAST) state  <= ST_STOP;
              end
              ST_STOP: begin
                if (sample_cnt == CNT_HI) state <= bit_val ? ST_IDLE : ST_WAIT_HIGH;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // NOTE: a load on the stop decision takes priority over clearing rx_valid,
  // so an accept in the same cycle hands straight over to the new word.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (stop_decide && can_load) begin
        rx_data    <= shift_q;
        rx_valid   <= 1'b1;
        frame_err  <= !bit_val;
        parity_err <= (PARITY_EN != 0) && perr_q;
      end else begin
        if (stop_decide)           overrun  <= 1'b1;
        if (rx_valid && rx_ready)  rx_valid <= 1'b0;
      end
    end
  end

endmodule
